// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_SAR = 4'hB;
  localparam logic [3:0] OP_ROL = 4'hC;
  localparam logic [3:0] OP_ROR = 4'hD;
  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Field order matches the FLAG_* bit indices.
  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_SAR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between operand source, ALU and result sink.
interface alu_seq_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, out_hi, flags, busy
  );

  modport slave (
    input  in_valid, op, in_a, in_b, out_ready,
    output in_ready, out_valid, out, out_hi, flags, busy
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Iterative shift/rotate (1 bit/cycle) and shift-add multiply, plus an unrolled
// single-cycle shifter; latency = loaded count, no backpressure (owner sequences it).
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last,
  output logic             mul_op,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi,
  output logic             nxt_c,
  output logic [WIDTH-1:0] comb_lo,
  output logic             comb_c
);

  localparam int CW = AW + 1;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   step;

  // Returns {bit shifted out, shifted value} for a single-bit move.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic [WIDTH-1:0] v);
    case (op)
      OP_SHR:  return {v[0], 1'b0, v[WIDTH-1:1]};
      OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SAR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  return {v[0], v[0], v[WIDTH-1:1]};
      default: return {1'b0, v};
    endcase
  endfunction

  assign amt    = b_in[AW-1:0];
  assign last   = (cnt_q == CW'(1));
  assign mul_op = (op_q == OP_MUL);

  always_comb begin
    sum    = {1'b0, hi_q} + (val_q[0] ? {1'b0, mcand_q} : '0);
    step   = shift_step(op_q, val_q);
    nxt_lo = step[WIDTH-1:0];
    nxt_hi = '0;
    nxt_c  = step[WIDTH];
    if (mul_op) begin
      // Partial product and multiplier share one shift register {hi_q, val_q}.
      nxt_lo = {sum[0], val_q[WIDTH-1:1]};
      nxt_hi = sum[WIDTH:1];
      nxt_c  = |sum[WIDTH:1];
    end
  end

  always_comb begin
    comb_lo = a_in;
    comb_c  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (AW'(i) < amt) {comb_c, comb_lo} = shift_step(op_in, comb_lo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      val_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      op_q    <= op_in;
      val_q   <= (op_in == OP_MUL) ? b_in : a_in;
      mcand_q <= a_in;
      hi_q    <= '0;
      cnt_q   <= (op_in == OP_MUL) ? CW'(WIDTH) : CW'(amt);
    end else if (cnt_q != '0) begin
      val_q <= nxt_lo;
      hi_q  <= nxt_hi;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops return next cycle, iterative shifts/MUL after
// amt/WIDTH extra cycles; result held until out_ready, no accept while executing.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit FAST_SHIFT = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int AW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             live_q;
  logic             in_ready, accept, multi;
  logic             load_single, load_iter, iter_start;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] a, b, res, sc_out;
  logic [WIDTH-1:0] out_q, hi_q;
  logic [WIDTH:0]   sum, diff;
  logic             add_cin, sub_cin, keep;
  flags_t           flags_q, sc_flags, it_flags;

  logic             it_last, it_mul, it_c, sh_c;
  logic [WIDTH-1:0] it_lo, it_hi, sh_lo;

  assign a   = bus.in_a;
  assign b   = bus.in_b;
  assign amt = b[AW-1:0];

  // live_q keeps requests blocked until the first edge after reset release.
  assign in_ready = live_q & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign multi    = (bus.op == OP_MUL) ||
                    ((FAST_SHIFT == 1'b0) && is_shift(bus.op) && (amt != '0));

  alu_iter_unit #(.WIDTH(WIDTH), .AW(AW)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_start),
    .op_in   (bus.op),
    .a_in    (a),
    .b_in    (b),
    .last    (it_last),
    .mul_op  (it_mul),
    .nxt_lo  (it_lo),
    .nxt_hi  (it_hi),
    .nxt_c   (it_c),
    .comb_lo (sh_lo),
    .comb_c  (sh_c)
  );

  // Carry-in is the flag register as it stands, i.e. already holding the
  // flags of a result being handed off this same cycle.
  assign add_cin = (bus.op == OP_ADC) & flags_q.c;
  assign sub_cin = (bus.op == OP_SBB) & flags_q.c;
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};

  always_comb begin
    res      = a;
    sc_flags = '0;
    keep     = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        res        = sum[WIDTH-1:0];
        sc_flags.c = sum[WIDTH];
        sc_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res        = diff[WIDTH-1:0];
        sc_flags.c = diff[WIDTH];
        sc_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHR, OP_SHL, OP_SAR, OP_ROL, OP_ROR: begin
        res        = sh_lo;
        sc_flags.c = sh_c;
      end
      default: keep = 1'b1;
    endcase
    sc_flags.n = res[WIDTH-1];
    sc_flags.z = (res == '0);
    if (keep) sc_flags = flags_q;
    sc_out = (bus.op == OP_CMP) ? a : res;
  end

  always_comb begin
    it_flags   = '0;
    it_flags.c = it_c;
    it_flags.v = it_mul & it_c;
    it_flags.n = it_lo[WIDTH-1];
    it_flags.z = (it_lo == '0);
  end

  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
    load_iter   = 1'b0;
    iter_start  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if ((state_q == ST_HOLD) && bus.out_ready) state_d = ST_IDLE;
        if (accept) begin
          if (multi) begin
            iter_start = 1'b1;
            state_d    = ST_EXEC;
          end else begin
            load_single = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_EXEC: begin
        if (it_last) begin
          load_iter = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (load_single) begin
        out_q   <= sc_out;
        hi_q    <= '0;
        flags_q <= sc_flags;
      end else if (load_iter) begin
        out_q   <= it_lo;
        hi_q    <= it_hi;
        flags_q <= it_flags;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q == ST_EXEC);
  assign bus.out       = out_q;
  assign bus.out_hi    = hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bs ();
  alu_seq_if #(.WIDTH(8)) bf ();

  alu_seq #(.WIDTH(8), .FAST_SHIFT(1'b0)) u_slow (.clk(clk), .rst_n(rst_n), .bus(bs));
  alu_seq #(.WIDTH(8), .FAST_SHIFT(1'b1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bf));

  logic       s_in_valid = 1'b0, f_in_valid = 1'b0;
  logic       s_out_ready = 1'b0, f_out_ready = 1'b0;
  logic [3:0] op_d = 4'h0;
  logic [7:0] a_d = 8'h0, b_d = 8'h0;

  assign bs.in_valid = s_in_valid;  assign bf.in_valid = f_in_valid;
  assign bs.out_ready = s_out_ready; assign bf.out_ready = f_out_ready;
  assign bs.op = op_d;  assign bf.op = op_d;
  assign bs.in_a = a_d; assign bf.in_a = a_d;
  assign bs.in_b = b_d; assign bf.in_b = b_d;

  bit         use_fast = 1'b0;
  logic       o_in_ready, o_out_valid, o_busy;
  logic [7:0] o_out, o_hi;
  logic [3:0] o_flags;

  always_comb begin
    o_in_ready  = use_fast ? bf.in_ready  : bs.in_ready;
    o_out_valid = use_fast ? bf.out_valid : bs.out_valid;
    o_busy      = use_fast ? bf.busy      : bs.busy;
    o_out       = use_fast ? bf.out       : bs.out;
    o_hi        = use_fast ? bf.out_hi    : bs.out_hi;
    o_flags     = use_fast ? bf.flags     : bs.flags;
  end

  int checks = 0;
  int failures = 0;
  logic [3:0] mflags [2];
  int         last_lat, last_busy;
  logic [7:0] last_out, last_hi;
  logic [3:0] last_fl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit operands, {C,N,V,Z} flags.
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] fin, output logic [7:0] lo, output logic [7:0] hi,
                                output logic [3:0] fo, output int lat);
    int ia, ib, sa, sb, amt, r, sr, cin, p;
    bit c, v;
    ia = int'(a); ib = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    amt = int'(b[2:0]); cin = int'(fin[FLAG_C]);
    c = 1'b0; v = 1'b0; r = ia; hi = 8'h00; lat = 1;
    case (op)
      OP_ADD, OP_ADC: begin
        if (op == OP_ADD) cin = 0;
        r = ia + ib + cin; sr = sa + sb + cin;
        c = (r > 255); v = (sr > 127) || (sr < -128);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        if (op != OP_SBB) cin = 0;
        r = ia - ib - cin; sr = sa - sb - cin;
        c = (r < 0); v = (sr > 127) || (sr < -128);
      end
      OP_OR:  r = ia | ib;
      OP_AND: r = ia & ib;
      OP_XOR: r = ia ^ ib;
      OP_NOT: r = ~ia & 255;
      OP_SHR: begin r = ia >> amt; c = (amt != 0) && (((ia >> (amt - 1)) & 1) == 1); end
      OP_SHL: begin r = (ia << amt) & 255; c = (amt != 0) && (((ia >> (8 - amt)) & 1) == 1); end
      OP_SAR: begin r = (sa >>> amt) & 255; c = (amt != 0) && (((ia >> (amt - 1)) & 1) == 1); end
      OP_ROL: begin r = ((ia << amt) | (ia >> (8 - amt))) & 255; c = (amt != 0) && ((r & 1) == 1); end
      OP_ROR: begin r = ((ia >> amt) | (ia << (8 - amt))) & 255; c = (amt != 0) && ((r & 128) != 0); end
      OP_MUL: begin p = ia * ib; r = p & 255; hi = 8'(p >> 8); c = (hi != 0); v = c; lat = 9; end
      default: r = ia;
    endcase
    if (is_shift(op)) lat = amt + 1;
    lo = 8'(r & 255);
    fo = {c, lo[7], v, (lo == 8'h00)};
    if (op == OP_CMP) lo = a;
    if (op == OP_NOP) fo = fin;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    #1;
    while (!o_in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!o_in_ready) check("in_ready_timeout", o_in_ready, 1);
    op_d = op; a_d = a; b_d = b;
    if (use_fast) f_in_valid = 1'b1; else s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0; f_in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int bc);
    lat = 1; bc = 0;
    while (!o_out_valid && lat <= 40) begin
      if (o_busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!o_out_valid) lat = -1;
  endtask

  task automatic consume();
    if (use_fast) f_out_ready = 1'b1; else s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0; f_out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] elo, ehi;
    logic [3:0] efl;
    int elat, lat, bc;
    model(op, a, b, mflags[use_fast], elo, ehi, efl, elat);
    if (use_fast && op != OP_MUL) elat = 1;
    issue(op, a, b);
    wait_result(lat, bc);
    last_lat = lat; last_busy = bc; last_out = o_out; last_hi = o_hi; last_fl = o_flags;
    check({tag, "_lat"}, lat, elat);
    check({tag, "_out"}, o_out, elo);
    check({tag, "_hi"}, o_hi, ehi);
    check({tag, "_flags"}, o_flags, efl);
    mflags[use_fast] = efl;
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] elo, ehi, saved_out;
    logic [3:0] efl, saved_fl;
    int elat, lat, bc;
    bit stable, seen;

    mflags[0] = 4'h0; mflags[1] = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bs.out_valid, 0);
    check("rst_busy", bs.busy, 0);
    check("rst_flags", bs.flags, 0);
    check("rst_out", bs.out, 0);
    check("rst_out_hi", bs.out_hi, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bs.in_ready, 1);

    run_op("add", OP_ADD, 8'h7F, 8'h01);
    check("add_k_out", last_out, 8'h80); check("add_k_fl", last_fl, 4'b0110); check("add_k_lat", last_lat, 1);
    run_op("sub", OP_SUB, 8'h00, 8'h01);
    check("sub_k_out", last_out, 8'hFF); check("sub_k_fl", last_fl, 4'b1100);
    run_op("adc", OP_ADC, 8'h01, 8'h01);
    check("adc_k_out", last_out, 8'h03); check("adc_k_c", last_fl[FLAG_C], 0);
    run_op("mul", OP_MUL, 8'h10, 8'h10);
    check("mul_k_out", last_out, 8'h00); check("mul_k_hi", last_hi, 8'h01);
    check("mul_k_fl", last_fl, 4'b1011); check("mul_k_lat", last_lat, 9); check("mul_k_busy", last_busy, 8);
    run_op("shl", OP_SHL, 8'h81, 8'h03);
    check("shl_k_out", last_out, 8'h08); check("shl_k_c", last_fl[FLAG_C], 0); check("shl_k_lat", last_lat, 4);
    run_op("ror", OP_ROR, 8'h01, 8'h01);
    check("ror_k_out", last_out, 8'h80); check("ror_k_cn", last_fl[3:2], 2'b11);
    run_op("shr0", OP_SHR, 8'hA5, 8'h08);
    check("shr0_k_lat", last_lat, 1); check("shr0_k_c", last_fl[FLAG_C], 0);

    use_fast = 1'b1;
    run_op("f_shl", OP_SHL, 8'h81, 8'h03);
    check("f_shl_k_lat", last_lat, 1); check("f_shl_k_out", last_out, 8'h08);
    run_op("f_ror", OP_ROR, 8'h01, 8'h01);
    check("f_ror_k_lat", last_lat, 1); check("f_ror_k_out", last_out, 8'h80);
    use_fast = 1'b0;

    // Backpressure, then a same-cycle handoff and accept.
    model(OP_XOR, 8'h3C, 8'h0F, mflags[0], elo, ehi, efl, elat);
    issue(OP_XOR, 8'h3C, 8'h0F);
    wait_result(lat, bc);
    check("bp_lat", lat, elat); check("bp_out", o_out, elo);
    mflags[0] = efl;
    saved_out = o_out; saved_fl = o_flags; stable = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (o_out !== saved_out || o_flags !== saved_fl || o_in_ready !== 1'b0 || o_out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    model(OP_ADD, 8'h05, 8'hFE, mflags[0], elo, ehi, efl, elat);
    op_d = OP_ADD; a_d = 8'h05; b_d = 8'hFE; s_in_valid = 1'b1; s_out_ready = 1'b1;
    #1 check("bp_in_ready", o_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    check("bp_next_valid", o_out_valid, 1); check("bp_next_out", o_out, elo); check("bp_next_fl", o_flags, efl);
    mflags[0] = efl;
    consume();

    for (int i = 0; i < 60; i++)
      run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    use_fast = 1'b1;
    for (int i = 0; i < 15; i++)
      run_op($sformatf("frnd%0d", i), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    use_fast = 1'b0;

    // Reset during MUL execution; in_valid held while in reset must be ignored.
    issue(OP_MUL, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    check("abort_busy_pre", bs.busy, 1);
    rst_n = 1'b0; op_d = OP_ADD; a_d = 8'h11; b_d = 8'h22; s_in_valid = 1'b1;
    #1;
    check("abort_out_valid", bs.out_valid, 0); check("abort_flags", bs.flags, 0);
    check("abort_busy", bs.busy, 0); check("abort_out", bs.out, 0);
    repeat (2) @(negedge clk);
    s_in_valid = 1'b0; rst_n = 1'b1;
    mflags[0] = 4'h0; mflags[1] = 4'h0;
    repeat (2) @(negedge clk);
    check("abort_in_ready", bs.in_ready, 1);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bs.out_valid) seen = 1'b1; end
    check("abort_no_result", seen, 0);
    run_op("post_rst_adc", OP_ADC, 8'h01, 8'h01);
    check("post_rst_k_out", last_out, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
